// File: rtl/rsa_cmd_ctrl.sv
// Left-to-right square-and-multiply sequencer for the modular exponentiation engine.
// Turns start/stop command pulses into load/square/multiply handshakes and status flags.
`timescale 1ns/1ps

module rsa_cmd_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start_cmd,
    input  logic             stop_cmd,
    input  logic [WIDTH-1:0] exponent,
    input  logic             mul_done,
    output logic             load_init,
    output logic             mul_start,
    output logic             mul_op,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SQUARE,
        SQ_WAIT,
        MULT,
        MUL_WAIT,
        NEXT,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] e_lat_reg, e_lat_next;
    logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic             aborted_reg, aborted_next;
    logic             busy_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            e_lat_reg   <= '0;
            bit_idx_reg <= LAST_IDX;
            aborted_reg <= 1'b0;
        end else if (ena) begin
            state_reg   <= state_next;
            e_lat_reg   <= e_lat_next;
            bit_idx_reg <= bit_idx_next;
            aborted_reg <= aborted_next;
        end
    end

    assign busy_state = (state_reg != IDLE) && (state_reg != DONE);

    always_comb begin
        state_next   = state_reg;
        e_lat_next   = e_lat_reg;
        bit_idx_next = bit_idx_reg;
        aborted_next = aborted_reg;

        case (state_reg)
            IDLE, DONE: begin
                // A simultaneous stop cancels the start; the pair changes nothing here.
                if (start_cmd && !stop_cmd) begin
                    e_lat_next   = exponent;
                    bit_idx_next = LAST_IDX;
                    aborted_next = 1'b0;
                    state_next   = INIT;
                end
            end
            INIT:     state_next = SQUARE;
            SQUARE:   state_next = SQ_WAIT;
            SQ_WAIT: begin
                if (mul_done) begin
                    state_next = e_lat_reg[bit_idx_reg] ? MULT : NEXT;
                end
            end
            MULT:     state_next = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (bit_idx_reg == '0) begin
                    state_next = DONE;
                end else begin
                    bit_idx_next = bit_idx_reg - 1'b1;
                    state_next   = SQUARE;
                end
            end
            default:  state_next = IDLE;
        endcase

        // Abort overrides any progress made by the schedule in the same cycle.
        if (busy_state && stop_cmd) begin
            state_next   = IDLE;
            aborted_next = 1'b1;
        end
    end

    assign load_init = ena && (state_reg == INIT);
    assign mul_start = ena && ((state_reg == SQUARE) || (state_reg == MULT));
    assign mul_op    = (state_reg == MULT);
    assign bit_idx   = bit_idx_reg;
    assign busy      = busy_state;
    assign done      = (state_reg == DONE);
    assign aborted   = aborted_reg;

endmodule
